bist_misr_analyzer: RTL

BIST response compactor: the read-side counterpart to the team's LFSR pattern generator. It compacts the circuit-under-test outputs (e.g. the c17 benchmark's two outputs) into a multiple-input signature register (MISR) over a fixed number of patterns. It then compares the signature against a golden value and reports pass/fail. It sits between the CUT outputs and the BIST controller.

---
 rtl/bist_pkg.sv | 19 +
 rtl/misr_core.sv | 39 +++
 rtl/bist_misr_analyzer.sv | 110 +++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared BIST types and the MISR step function (same tap convention as the LFSR generator).
package bist_pkg;

  typedef enum logic [1:0] {StIdle, StCompact, StCompare, StDone} state_e;

  // Widest signature misr_next can handle.
  localparam int unsigned MisrMaxW = 64;

  localparam logic [4:0] DefaultPoly5 = 5'b10100;

  // Shift left, feedback into bit 0, then fold in the response. Callers zero-extend their
  // operands and keep only their own low bits, so one function serves every width.
  function automatic logic [MisrMaxW-1:0] misr_next(input logic [MisrMaxW-1:0] sig,
                                                     input logic [MisrMaxW-1:0] resp,
                                                     input logic [MisrMaxW-1:0] poly);
    misr_next = {sig[MisrMaxW-2:0], ^(sig & poly)} ^ resp;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: load has priority over a compaction step.
module misr_core
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH  = 5,
  parameter int unsigned      RESP_W = 2,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(DefaultPoly5),
  parameter logic [WIDTH-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [WIDTH-1:0]  sig
);

  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = WIDTH'(misr_next(MisrMaxW'(sig_q), MisrMaxW'(resp), MisrMaxW'(POLY)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST response compactor: MISR over PATTERN_COUNT responses, then golden compare.
// Optional X-masking of response bits when BIST_MISR_XMASK_EN is defined.
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH         = 5,
  parameter int unsigned      RESP_W        = 2,
  parameter int unsigned      PATTERN_COUNT = 31,
  parameter logic [WIDTH-1:0] POLY          = WIDTH'(DefaultPoly5),
  parameter logic [WIDTH-1:0] SEED          = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 resp_valid,
  input  logic [RESP_W-1:0]                    resp_data,
`ifdef BIST_MISR_XMASK_EN
  input  logic [RESP_W-1:0]                    resp_mask,
`endif
  input  logic [WIDTH-1:0]                     golden_sig,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [WIDTH-1:0]                     signature,
  output logic [$clog2(PATTERN_COUNT+1)-1:0]   pat_count
);

  localparam int unsigned     CntW    = $clog2(PATTERN_COUNT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(PATTERN_COUNT - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(PATTERN_COUNT);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pass_q, pass_d;
  logic              misr_load, misr_en;
  logic [RESP_W-1:0] comp_resp;

`ifdef BIST_MISR_XMASK_EN
  assign comp_resp = resp_data & ~resp_mask;
`else
  assign comp_resp = resp_data;
`endif

  misr_core #(
    .WIDTH  (WIDTH),
    .RESP_W (RESP_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .load  (misr_load),
    .en    (misr_en),
    .resp  (comp_resp),
    .sig   (signature)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // A response arriving with start is dropped; the run begins clean.
        if (start) begin
          misr_load = 1'b1;
          cnt_d     = '0;
          pass_d    = 1'b0;
          state_d   = StCompact;
        end
      end
      StCompact: begin
        if (resp_valid) begin
          misr_en = 1'b1;
          if (cnt_q != MaxCnt) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q == LastCnt) begin
            state_d = StCompare;
          end
        end
      end
      StCompare: begin
        pass_d  = (signature == golden_sig);
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == StCompact) || (state_q == StCompare);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign pat_count = cnt_q;

endmodule
